// File: rtl/polyunit_host_if_if.sv
// polyunit_host_if_if: bus between the host driver and the polynomial NTT core.
// The master modport is the host side; the slave modport is the core side.
interface polyunit_host_if_if #(
  parameter int DWID = 48,
  parameter int AWID = 5
);
  logic [1:0]      core_mode;
  logic            core_run;
  logic [DWID-1:0] core_data_in;
  logic [AWID-1:0] core_data_in_add;
  logic            core_data_in_done;
  logic [DWID-1:0] core_data_out;
  logic            core_done;

  modport master (
    output core_mode,
    output core_run,
    output core_data_in,
    output core_data_in_add,
    output core_data_in_done,
    input  core_data_out,
    input  core_done
  );

  modport slave (
    input  core_mode,
    input  core_run,
    input  core_data_in,
    input  core_data_in_add,
    input  core_data_in_done,
    output core_data_out,
    output core_done
  );
endinterface

// File: rtl/polyunit_host_if.sv
// polyunit_host_if: host-side driver for the polynomial NTT core.
// Packs a 256-coefficient stream four-per-word into the core RAM, issues
// NTT/INTT runs, and reads the RAM back into a buffer that is unpacked to a
// valid/ready coefficient stream. The word address is the coefficient index
// divided by four, truncated to AWID bits.
// Optional watchdog: define POLYUNIT_HOST_TIMEOUT_EN to add timeout_err and
// bound the waits for core_done.
module polyunit_host_if #(
  parameter int WID     = 12,
  parameter int DWID    = 48,
  parameter int AWID    = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic [1:0]     cmd_op,
  output logic           cmd_ready,
  input  logic [WID-1:0] coef_in,
  input  logic           coef_in_valid,
  output logic           coef_in_ready,
  output logic [WID-1:0] coef_out,
  output logic           coef_out_valid,
  input  logic           coef_out_ready,
  output logic           coef_out_last,
  output logic           busy,
`ifdef POLYUNIT_HOST_TIMEOUT_EN
  output logic           timeout_err,
`endif
  polyunit_host_if_if.master core
);

  localparam int NWORDS = 1 << AWID;
  localparam int LAT_W  = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] RD_LAT_L = LAT_W'(RD_LAT);

  localparam logic [1:0] OP_LOAD   = 2'd2;
  localparam logic [1:0] OP_UNLOAD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_LOAD     = 3'd2,
    S_LOAD_FIN = 3'd3,
    S_UNLOAD   = 3'd4,
    S_WAIT     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  // Load path: current word presented to the core and the partial next word
  logic [DWID-1:0]     din_q, din_d;
  logic [AWID-1:0]     dadd_q, dadd_d;
  logic [3*WID-1:0]    pack_q, pack_d;
  logic [7:0]          in_idx_q, in_idx_d;
  logic                in_done_q, in_done_d;
  // Unload path: capture side and drain side run independently
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [AWID-1:0]     cap_idx_q, cap_idx_d;
  logic                cap_done_q, cap_done_d;
  logic [NWORDS-1:0]   vld_q, vld_d;
  logic [7:0]          out_idx_q, out_idx_d;
  logic                out_done_q, out_done_d;
  logic                done_seen_q, done_seen_d;

  logic [DWID-1:0]     buf_q [NWORDS];
  logic                buf_we;
  logic [DWID-1:0]     rd_word;
  logic                in_hs;
  logic                out_hs;

`ifdef POLYUNIT_HOST_TIMEOUT_EN
  logic [7:0]          wd_q, wd_d;
  logic                wd_en;
  logic                wd_fire;
`endif

  // Handshake and status decode from the registered state
  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign coef_in_ready  = (state_q == S_LOAD) & ~in_done_q;
  assign rd_word        = buf_q[out_idx_q[AWID+1:2]];
  assign coef_out_valid = (state_q == S_UNLOAD) & ~out_done_q & vld_q[out_idx_q[AWID+1:2]];
  assign coef_out       = coef_out_valid ? rd_word[out_idx_q[1:0]*WID +: WID] : '0;
  assign coef_out_last  = coef_out_valid & (&out_idx_q);
  assign in_hs          = coef_in_valid & coef_in_ready;
  assign out_hs         = coef_out_valid & coef_out_ready;

  assign core.core_mode         = mode_q;
  assign core.core_run          = (state_q == S_RUN);
  assign core.core_data_in      = din_q;
  assign core.core_data_in_add  = dadd_q;
  assign core.core_data_in_done = (state_q == S_LOAD_FIN);

`ifdef POLYUNIT_HOST_TIMEOUT_EN
  assign timeout_err = wd_fire;
`endif

  // Next-state and datapath update for every register
  // NOTE: each _d takes its held value before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    din_d       = din_q;
    dadd_d      = dadd_q;
    pack_d      = pack_q;
    in_idx_d    = in_idx_q;
    in_done_d   = in_done_q;
    lat_d       = lat_q;
    cap_idx_d   = cap_idx_q;
    cap_done_d  = cap_done_q;
    vld_d       = vld_q;
    out_idx_d   = out_idx_q;
    out_done_d  = out_done_q;
    done_seen_d = done_seen_q;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // A new command starts from a clean slate: address 0, empty buffer
          state_d     = S_RUN;
          mode_d      = cmd_op;
          din_d       = '0;
          dadd_d      = '0;
          pack_d      = '0;
          in_idx_d    = '0;
          in_done_d   = 1'b0;
          lat_d       = '0;
          cap_idx_d   = '0;
          cap_done_d  = 1'b0;
          vld_d       = '0;
          out_idx_d   = '0;
          out_done_d  = 1'b0;
          done_seen_d = 1'b0;
        end
      end

      S_RUN: begin
        case (mode_q)
          OP_LOAD:   state_d = S_LOAD;
          OP_UNLOAD: state_d = S_UNLOAD;
          default:   state_d = S_WAIT;
        endcase
      end

      S_LOAD: begin
        if (in_done_q) begin
          // Last word has now been on the bus for a full cycle
          state_d = S_LOAD_FIN;
        end else if (in_hs) begin
          case (in_idx_q[1:0])
            2'd0:    pack_d[WID-1:0]       = coef_in;
            2'd1:    pack_d[2*WID-1:WID]   = coef_in;
            2'd2:    pack_d[3*WID-1:2*WID] = coef_in;
            default: begin
              // The core writes every cycle, so the word stays put until the next one completes
              din_d  = {coef_in, pack_q};
              dadd_d = in_idx_q[AWID+1:2];
            end
          endcase
          in_idx_d = in_idx_q + 8'd1;
          if (&in_idx_q) in_done_d = 1'b1;
        end
      end

      S_LOAD_FIN: state_d = S_WAIT;

      S_WAIT: begin
        if (core.core_done) state_d = S_IDLE;
      end

      S_UNLOAD: begin
        // Capture is free-running once the read latency has elapsed
        if (lat_q != RD_LAT_L) begin
          lat_d = lat_q + 1'b1;
        end else if (!cap_done_q) begin
          buf_we           = 1'b1;
          vld_d[cap_idx_q] = 1'b1;
          cap_idx_d        = cap_idx_q + 1'b1;
          if (&cap_idx_q) cap_done_d = 1'b1;
        end
        if (out_hs) begin
          out_idx_d = out_idx_q + 8'd1;
          if (&out_idx_q) out_done_d = 1'b1;
        end
        if (core.core_done) done_seen_d = 1'b1;
        if ((out_done_q | (out_hs & (&out_idx_q))) & (done_seen_q | core.core_done)) begin
          state_d = S_IDLE;
          vld_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef POLYUNIT_HOST_TIMEOUT_EN
    // Watchdog covers every state that waits on core_done
    wd_en   = (state_q == S_LOAD_FIN) | (state_q == S_WAIT) |
              ((state_q == S_UNLOAD) & cap_done_q);
    wd_fire = wd_en & (wd_q == 8'(TIMEOUT)) & ~(done_seen_q | core.core_done);
    wd_d    = wd_en ? (wd_q + 8'd1) : 8'd0;
    if (wd_fire) begin
      state_d = S_IDLE;
      vld_d   = '0;
      wd_d    = 8'd0;
    end
`endif
  end

  // State and control registers with synchronous reset
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      din_q       <= '0;
      dadd_q      <= '0;
      pack_q      <= '0;
      in_idx_q    <= '0;
      in_done_q   <= 1'b0;
      lat_q       <= '0;
      cap_idx_q   <= '0;
      cap_done_q  <= 1'b0;
      vld_q       <= '0;
      out_idx_q   <= '0;
      out_done_q  <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      din_q       <= din_d;
      dadd_q      <= dadd_d;
      pack_q      <= pack_d;
      in_idx_q    <= in_idx_d;
      in_done_q   <= in_done_d;
      lat_q       <= lat_d;
      cap_idx_q   <= cap_idx_d;
      cap_done_q  <= cap_done_d;
      vld_q       <= vld_d;
      out_idx_q   <= out_idx_d;
      out_done_q  <= out_done_d;
      done_seen_q <= done_seen_d;
    end
  end

`ifdef POLYUNIT_HOST_TIMEOUT_EN
  // Watchdog counter
  always_ff @(posedge clk) begin
    if (rst) wd_q <= 8'd0;
    else     wd_q <= wd_d;
  end
`endif

  // Unload buffer write port
  // NOTE: the buffer array has no reset; vld_q gates every read of it.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cap_idx_q] <= core.core_data_out;
  end

endmodule

// File: doc/polyunit_host_if.md
Name: polyunit_host_if

Overview:
- Host-side driver for the polynomial NTT core.
- Accepts a 256-coefficient polynomial as a 12-bit stream, packs it 4-per-word and loads the core's 32x48 RAM via the core's data-in port. Issues NTT/INTT run commands.
- Reads the core's RAM back through its data-out stream, buffers the words, and unpacks them to a 12-bit stream with valid/ready backpressure.
- Sits between the Kyber top-level controller and the poly core.

Parameters:
- WID, 12, coefficient width
- DWID, 48, core RAM word width (4*WID)
- AWID, 5, core RAM address width (32 words)
- RD_LAT, 1, cycles from core read address k to word k on core_data_out
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  2  0=NTT, 1=INTT, 2=LOAD, 3=UNLOAD (same as core mode encoding)
- cmd_ready  out  1  high only in IDLE
- coef_in  in  WID  load coefficient
- coef_in_valid  in  1  load stream valid
- coef_in_ready  out  1  load stream ready
- coef_out  out  WID  unload coefficient
- coef_out_valid  out  1  unload stream valid
- coef_out_ready  in  1  unload stream ready
- coef_out_last  out  1  high with coefficient 255
- busy  out  1  not IDLE
- core_mode  out  2  to core mode
- core_run  out  1  to core run, 1-cycle pulse
- core_data_in  out  DWID  to core data_in
- core_data_in_add  out  AWID  to core data_in_add
- core_data_in_done  out  1  to core data_in_done, 1-cycle pulse
- core_data_out  in  DWID  from core data_out
- core_done  in  1  from core done

Behaviour:
- Reset state: IDLE. All registered outputs are 0. cmd_ready=1 and busy=0 while in IDLE. The unload buffer is invalid. Counters are cleared. Reset mid-operation aborts with no further core_run or done pulses.
- States: IDLE, RUN, LOAD, LOAD_FIN, UNLOAD, WAIT.
- Command acceptance: cmd_valid & cmd_ready in IDLE latches op into core_mode and goes to RUN. Other cmd_op values are not possible (2-bit field).
- RUN: core_run=1 for exactly this one cycle (cycle T). Next state is LOAD (op 2), UNLOAD (op 3), or WAIT (op 0/1).
- Packing: coefficient 4a+i occupies core_data_in bits [12i+11:12i] of word a.
- LOAD (from T+1):
  - coef_in_ready=1 while fewer than 256 coefficients have been accepted; one coefficient per handshake.
  - On the 4th coefficient of word a, core_data_in and core_data_in_add=a update the next cycle and are held until word a+1 completes. The core writes every cycle, so holding is mandatory.
  - Before word 0 completes, the outputs stay at data 0 / address 0.
  - After word 31 has been presented for 1 cycle, go to LOAD_FIN.
- LOAD_FIN: core_data_in_done=1 for one cycle with word 31 still held, then go to WAIT.
- UNLOAD:
  - Capture core_data_out into a 32x48 buffer at cycles T+1+RD_LAT+k, k=0..31. Capture is free-running and ignores coef_out_ready.
  - Word k is marked valid at capture.
  - Drain runs concurrently: coef_out_valid=1 when the word holding the current coefficient is valid. Coefficients are output in order 0..255, low slice first.
  - coef_out_last=1 on index 255.
  - Exit to IDLE once both the last handshake has completed and core_done has been seen (latched sticky if it arrives earlier).
- WAIT: stay until core_done=1, then go to IDLE on the next cycle.
- Simultaneous cmd_valid and core_done in WAIT: the command is not accepted until IDLE.
- Counters: coefficient index is 8-bit and wraps at 255->0 only at completion; word index is 5-bit.

Optional Feature:
- Macro: POLYUNIT_HOST_TIMEOUT_EN.
- Enabled:
  - Adds output `timeout_err` (1 bit).
  - A 8-bit watchdog counts cycles in WAIT and LOAD_FIN, and in UNLOAD after capture of word 31.
  - If TIMEOUT is reached without core_done, pulse timeout_err for 1 cycle and return to IDLE.
  - The unload buffer is invalidated.
- Disabled: the port and counter are absent, and waits are unbounded.

Test Plan:
- LOAD: stream coef i = i (0..255) with no stalls. Expect core_run pulse with mode=2, then core_data_in_add 0..31 in order. Word 0 = 0x003002001000. core_data_in_done one cycle after word 31 (0x0FF0FE0FD0FC) appears. Back to IDLE after core_done.
- LOAD with coef_in_valid toggling every other cycle. Expect the same words. Each word is held unchanged until the next one completes.
- NTT: cmd_op=0. Expect one core_run with core_mode=0, busy until core_done, cmd_ready=1 the cycle after core_done.
- UNLOAD with model core returning word k = {4{k[11:0]}}, coef_out_ready=1. Expect coefficients 0,0,0,0,1,1,... and coef_out_last on the 256th value (31).
- UNLOAD with coef_out_ready low for 40 cycles after the command. Expect all 32 words captured with no loss; 256 correct coefficients drained after ready rises.
- Reset asserted mid-LOAD at word 10. Expect all outputs 0 next cycle and IDLE. A new LOAD then restarts at address 0.
